// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared playfield constants and projectile mode encoding
package game_pkg;

  localparam int GAME_X_W      = 8;
  localparam int GAME_Y_W      = 7;
  localparam int GAME_SCREEN_W = 160;
  localparam int GAME_SCREEN_H = 120;

  typedef enum logic {
    MODE_STRAIGHT = 1'b0,
    MODE_HOMING   = 1'b1
  } mode_e;

endpackage

// File: rtl/projectile_slot.sv
// rtl/projectile_slot.sv - one projectile: spawn, movement, hit and off-screen retirement
module projectile_slot import game_pkg::*; #(
  parameter int X_W      = GAME_X_W,
  parameter int Y_W      = GAME_Y_W,
  parameter int SCREEN_W = GAME_SCREEN_W,
  parameter int SCREEN_H = GAME_SCREEN_H,
  parameter int HIT_R    = 5
) (
  input  logic           clk_i,
  input  logic           resetn_i,
  input  logic           clear_i,
  input  logic           tick_i,
  input  logic           mode_i,
  input  logic           alloc_i,
  input  logic [X_W-1:0] fire_x_i,
  input  logic [Y_W-1:0] fire_y_i,
  input  logic [X_W-1:0] target_x_i,
  input  logic [Y_W-1:0] target_y_i,
  output logic           active_o,
  output logic           active_nxt_o,
  output logic           hit_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o
);

  // Window bounds widened by one bit so the signed distance never wraps near 0.
  localparam logic signed [X_W:0] HIT_RX = (X_W+1)'(HIT_R);
  localparam logic signed [Y_W:0] HIT_RY = (Y_W+1)'(HIT_R);
  localparam logic [X_W:0]        SCR_W  = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]        SCR_H  = (Y_W+1)'(SCREEN_H);

  logic                active_q, active_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic signed [X_W:0] dx;
  logic signed [Y_W:0] dy;
  logic                in_window;
  logic                offscreen;

  assign dx        = $signed({1'b0, x_q}) - $signed({1'b0, target_x_i});
  assign dy        = $signed({1'b0, y_q}) - $signed({1'b0, target_y_i});
  assign in_window = (dx <= HIT_RX) && (dx >= -HIT_RX) && (dy <= HIT_RY) && (dy >= -HIT_RY);
  assign offscreen = ({1'b0, x_q} >= SCR_W) || ({1'b0, y_q} >= SCR_H);
  assign hit_o     = active_q && tick_i && !clear_i && in_window;

  // Next slot state: clear beats spawn, spawn only targets idle slots, tick moves live ones.
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    if (clear_i) begin
      active_d = 1'b0;
    end else if (alloc_i) begin
      active_d = 1'b1;
      x_d      = fire_x_i;
      y_d      = fire_y_i;
    end else if (tick_i && active_q) begin
      if (in_window || offscreen) begin
        active_d = 1'b0;
      end else if (mode_i == MODE_STRAIGHT) begin
        if (y_q == '0) active_d = 1'b0;
        else           y_d      = y_q - Y_W'(1);
      end else begin
        if (x_q < target_x_i)      x_d = x_q + X_W'(1);
        else if (x_q > target_x_i) x_d = x_q - X_W'(1);
        if (y_q < target_y_i)      y_d = y_q + Y_W'(1);
        else if (y_q > target_y_i) y_d = y_q - Y_W'(1);
      end
    end
  end

  // Slot state register; reset kills the slot outright so no half-applied move survives.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign active_o     = active_q;
  assign active_nxt_o = active_d;
  assign x_o          = x_q;
  assign y_o          = y_q;

endmodule

// File: rtl/projectile_pool.sv
// rtl/projectile_pool.sv - projectile pool: slot allocation, occupancy count and pixel lookup
module projectile_pool import game_pkg::*; #(
  parameter int N_PROJ   = 10,
  parameter int X_W      = GAME_X_W,
  parameter int Y_W      = GAME_Y_W,
  parameter int SCREEN_W = GAME_SCREEN_W,
  parameter int SCREEN_H = GAME_SCREEN_H,
  parameter int HIT_R    = 5,
  localparam int CNT_W   = $clog2(N_PROJ + 1)
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             clear,
  input  logic             tick,
  input  logic             mode,
  input  logic             fire_req,
  input  logic [X_W-1:0]   fire_x,
  input  logic [Y_W-1:0]   fire_y,
  input  logic [X_W-1:0]   target_x,
  input  logic [Y_W-1:0]   target_y,
  input  logic [X_W-1:0]   pix_x,
  input  logic [Y_W-1:0]   pix_y,
  output logic             fire_ack,
  output logic             fire_drop,
  output logic             hit_pulse,
  output logic             pix_on,
  output logic [CNT_W-1:0] active_cnt
);

  logic [N_PROJ-1:0] act_q, act_d, alloc, hit;
  logic [X_W-1:0]    slot_x [N_PROJ];
  logic [Y_W-1:0]    slot_y [N_PROJ];
  logic              fire_ok, any_free, pix_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              fire_ack_q, fire_drop_q, hit_pulse_q, pix_on_q;
  logic [CNT_W-1:0]  active_cnt_q;

  assign fire_ok  = fire_req && !clear;
  assign any_free = !(&act_q);

  // Lowest-index idle slot, judged on pre-edge occupancy so slots freed this cycle wait a cycle.
  always_comb begin
    logic found;
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < N_PROJ; i++) begin
      if (!act_q[i] && !found) begin
        alloc[i] = fire_ok;
        found    = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_PROJ; gi++) begin : g_slot
    projectile_slot #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .HIT_R    (HIT_R)
    ) u_slot (
      .clk_i        (CLOCK_50),
      .resetn_i     (resetn),
      .clear_i      (clear),
      .tick_i       (tick),
      .mode_i       (mode),
      .alloc_i      (alloc[gi]),
      .fire_x_i     (fire_x),
      .fire_y_i     (fire_y),
      .target_x_i   (target_x),
      .target_y_i   (target_y),
      .active_o     (act_q[gi]),
      .active_nxt_o (act_d[gi]),
      .hit_o        (hit[gi]),
      .x_o          (slot_x[gi]),
      .y_o          (slot_y[gi])
    );
  end

  // Pixel lookup over current slots and occupancy count of the slots being written this edge.
  always_comb begin
    pix_d = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      if (act_q[i] && slot_x[i] == pix_x && slot_y[i] == pix_y) pix_d = 1'b1;
      cnt_d = cnt_d + CNT_W'(act_d[i]);
    end
  end

  // Registered status pulses and counters.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      fire_ack_q   <= 1'b0;
      fire_drop_q  <= 1'b0;
      hit_pulse_q  <= 1'b0;
      pix_on_q     <= 1'b0;
      active_cnt_q <= '0;
    end else begin
      fire_ack_q   <= fire_ok && any_free;
      fire_drop_q  <= fire_ok && !any_free;
      hit_pulse_q  <= |hit;
      pix_on_q     <= pix_d;
      active_cnt_q <= cnt_d;
    end
  end

  assign fire_ack   = fire_ack_q;
  assign fire_drop  = fire_drop_q;
  assign hit_pulse  = hit_pulse_q;
  assign pix_on     = pix_on_q;
  assign active_cnt = active_cnt_q;

endmodule

// File: tb/tb_projectile_pool.sv
// tb/tb_projectile_pool.sv - randomized and directed bench for projectile_pool against a slot-list model
module tb_projectile_pool;

  localparam int N     = 10;
  localparam int HIT_R = 5;
  localparam int SW    = 160;
  localparam int SH    = 120;

  logic       CLOCK_50 = 1'b0;
  logic       resetn, clear, tick, mode, fire_req;
  logic [7:0] fire_x, target_x, pix_x;
  logic [6:0] fire_y, target_y, pix_y;
  logic       fire_ack, fire_drop, hit_pulse, pix_on;
  logic [3:0] active_cnt;

  int checks = 0;
  int errors = 0;

  int m_act [N];
  int m_x   [N];
  int m_y   [N];
  int e_ack, e_drop, e_hit, e_pix, e_cnt;

  projectile_pool dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .clear      (clear),
    .tick       (tick),
    .mode       (mode),
    .fire_req   (fire_req),
    .fire_x     (fire_x),
    .fire_y     (fire_y),
    .target_x   (target_x),
    .target_y   (target_y),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .fire_ack   (fire_ack),
    .fire_drop  (fire_drop),
    .hit_pulse  (hit_pulse),
    .pix_on     (pix_on),
    .active_cnt (active_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
  endtask

  // Apply one clock of the pool rules to the model using the current inputs.
  task automatic model_step();
    int nact [N];
    int nx   [N];
    int ny   [N];
    int free_i, dx, dy;
    e_pix = 0; e_ack = 0; e_drop = 0; e_hit = 0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i] != 0 && m_x[i] == int'(pix_x) && m_y[i] == int'(pix_y)) e_pix = 1;
      nact[i] = m_act[i];
      nx[i]   = m_x[i];
      ny[i]   = m_y[i];
    end
    if (clear) begin
      for (int i = 0; i < N; i++) nact[i] = 0;
    end else begin
      free_i = -1;
      for (int i = N - 1; i >= 0; i--) if (m_act[i] == 0) free_i = i;
      if (tick) begin
        for (int i = 0; i < N; i++) begin
          if (m_act[i] != 0) begin
            dx = m_x[i] - int'(target_x);
            dy = m_y[i] - int'(target_y);
            if (dx <= HIT_R && dx >= -HIT_R && dy <= HIT_R && dy >= -HIT_R) begin
              nact[i] = 0;
              e_hit   = 1;
            end else if (m_x[i] >= SW || m_y[i] >= SH) begin
              nact[i] = 0;
            end else if (mode == 1'b0) begin
              if (m_y[i] == 0) nact[i] = 0;
              else             ny[i]   = m_y[i] - 1;
            end else begin
              if (int'(target_x) > m_x[i]) nx[i] = m_x[i] + 1;
              if (int'(target_x) < m_x[i]) nx[i] = m_x[i] - 1;
              if (int'(target_y) > m_y[i]) ny[i] = m_y[i] + 1;
              if (int'(target_y) < m_y[i]) ny[i] = m_y[i] - 1;
            end
          end
        end
      end
      if (fire_req) begin
        if (free_i >= 0) begin
          nact[free_i] = 1;
          nx[free_i]   = int'(fire_x);
          ny[free_i]   = int'(fire_y);
          e_ack        = 1;
        end else begin
          e_drop = 1;
        end
      end
    end
    e_cnt = 0;
    for (int i = 0; i < N; i++) begin
      m_act[i] = nact[i];
      m_x[i]   = nx[i];
      m_y[i]   = ny[i];
      e_cnt   += nact[i];
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("fire_ack", fire_ack, e_ack);
    check("fire_drop", fire_drop, e_drop);
    check("hit_pulse", hit_pulse, e_hit);
    check("pix_on", pix_on, e_pix);
    check("active_cnt", active_cnt, e_cnt);
  endtask

  task automatic idle();
    clear = 1'b0; tick = 1'b0; fire_req = 1'b0;
  endtask

  task automatic fire_at(input int x, input int y);
    idle();
    fire_req = 1'b1; fire_x = 8'(x); fire_y = 7'(y);
    cycle();
    fire_req = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_ack"}, fire_ack, 0);
    check({tag, "_drop"}, fire_drop, 0);
    check({tag, "_hit"}, hit_pulse, 0);
    check({tag, "_pix"}, pix_on, 0);
    check({tag, "_cnt"}, active_cnt, 0);
  endtask

  initial begin
    int acks, ticks_to_hit, pick;
    resetn = 1'b0; mode = 1'b0;
    fire_x = '0; fire_y = '0; target_x = 8'd200; target_y = 7'd100; pix_x = '0; pix_y = '0;
    idle();
    model_reset();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_outputs_zero("reset");
    resetn = 1'b1;

    // Spawn at (83,59), then three straight-up ticks land on y=56.
    fire_at(83, 59);
    check("r039_ack", fire_ack, 1);
    check("r039_cnt", active_cnt, 1);
    tick = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    tick = 1'b0;
    pix_x = 8'd83; pix_y = 7'd56;
    cycle();
    check("r039_y56", pix_on, 1);

    // Eleven requests into an empty pool: ten accepted, the last dropped.
    do_clear();
    acks = 0;
    for (int i = 0; i < 11; i++) begin
      fire_at(20 + i, 100);
      if (fire_ack) acks++;
    end
    check("r040_acks", acks, 10);
    check("r040_drop", fire_drop, 1);
    check("r040_cnt", active_cnt, 10);

    // Full pool where every slot retires on this tick: the request still sees a full pool.
    do_clear();
    for (int i = 0; i < N; i++) fire_at(100, 0);
    target_x = 8'd250; target_y = 7'd120;
    fire_req = 1'b1; tick = 1'b1; fire_x = 8'd5; fire_y = 7'd5;
    cycle();
    check("r021_drop", fire_drop, 1);
    check("r021_cnt", active_cnt, 0);
    fire_at(5, 5);
    check("r021_ack_next", fire_ack, 1);

    // Homing from (50,30) toward (40,30): hit once the pre-move x is 45.
    do_clear();
    mode = 1'b1; target_x = 8'd40; target_y = 7'd30;
    fire_at(50, 30);
    ticks_to_hit = 0;
    tick = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (hit_pulse && ticks_to_hit == 0) ticks_to_hit = i;
      if (ticks_to_hit != 0) break;
    end
    tick = 1'b0;
    check("r041_ticks", ticks_to_hit, 6);
    check("r041_cnt", active_cnt, 0);

    // Near-origin hit window must not wrap.
    mode = 1'b0; target_x = 8'd0; target_y = 7'd0;
    fire_at(2, 2);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    check("r042_hit", hit_pulse, 1);

    // Clear overrides fire and tick in the same cycle.
    target_x = 8'd200; target_y = 7'd100;
    fire_at(70, 70);
    fire_req = 1'b1; tick = 1'b1; clear = 1'b1;
    cycle();
    idle();
    check("r043_ack", fire_ack, 0);
    check("r043_drop", fire_drop, 0);
    check("r043_cnt", active_cnt, 0);

    // Pixel query on and off the projectile.
    fire_at(10, 20);
    pix_x = 8'd10; pix_y = 7'd20;
    cycle();
    check("r044_on", pix_on, 1);
    pix_y = 7'd21;
    cycle();
    check("r044_off", pix_on, 0);

    // Randomized traffic with one asynchronous reset mid-run.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        fire_req = 1'b1; tick = 1'b1; clear = 1'b0;
        #2 resetn = 1'b0;
        #1 reset_outputs_zero("midreset");
        model_reset();
        @(negedge CLOCK_50);
        resetn = 1'b1;
        idle();
      end
      clear    = ($urandom_range(0, 99) < 2);
      fire_req = ($urandom_range(0, 99) < 35);
      tick     = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      fire_x = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
      fire_y = 7'($urandom_range(0, 127));
      if (n % 50 == 0) begin
        target_x = 8'($urandom_range(0, 159));
        target_y = 7'($urandom_range(0, 119));
      end
      pick = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1 && m_act[pick] != 0) begin
        pix_x = 8'(m_x[pick]);
        pix_y = 7'(m_y[pick]);
      end else begin
        pix_x = 8'($urandom_range(0, 255));
        pix_y = 7'($urandom_range(0, 127));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
